// File: rtl/sync_fifo_fwft_thr.sv
// Single-clock FIFO with selectable registered/fall-through read, programmable
// almost-full/almost-empty thresholds, arbitrary depth, flush and sticky error flags.
module sync_fifo_fwft_thr #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 15,
  parameter int FWFT   = 0,
  parameter int AF_THR = DEPTH - 2,
  parameter int AE_THR = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    used_cnt,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  // Explicit wrap at DEPTH-1 so non-power-of-2 depths index the array correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + {{(PW-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    used_cnt_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             empty_s;
  logic             full_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Occupancy flags and accept qualifiers, all from the registered count.
  always_comb begin
    empty_s  = (used_cnt_r == {CW{1'b0}});
    full_s   = (used_cnt_r == CW'(DEPTH));
    wr_acc_s = wr & ~full_s & ~flush;
    rd_acc_s = rd & ~empty_s & ~flush;
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      used_cnt_r <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      used_cnt_r <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   used_cnt_r <= used_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   used_cnt_r <= used_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        default: used_cnt_r <= used_cnt_r;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (wr & full_s & ~flush) | (overflow_r & ~err_clr);
      underflow_r <= (rd & empty_s & ~flush) | (underflow_r & ~err_clr);
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] dout_r;
      // Registered read port: word appears the cycle after rd is accepted.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_r <= {WIDTH{1'b0}};
        end else if (rd_acc_s) begin
          dout_r <= mem_r[rd_ptr_r];
        end else begin
          dout_r <= dout_r;
        end
      end
      assign dout = dout_r;
    end else begin : g_fwft_read
      assign dout = mem_r[rd_ptr_r];
    end
  endgenerate

  assign used_cnt     = used_cnt_r;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (used_cnt_r >= CW'(AF_THR));
  assign almost_empty = (used_cnt_r <= CW'(AE_THR));
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_fwft_thr.sv
// Drives a registered-read and a fall-through instance with identical stimulus and
// scores both against a reference queue of accepted writes.
module tb_sync_fifo_fwft_thr;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 15;
  localparam int AF_THR = 13;
  localparam int AE_THR = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic             t_clk;
  logic             rst;
  logic             flush;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic             err_clr;

  logic [WIDTH-1:0] dout_reg, dout_fw;
  logic [CW-1:0]    used_reg, used_fw;
  logic             empty_reg, empty_fw, full_reg, full_fw;
  logic             af_reg, af_fw, ae_reg, ae_fw;
  logic             ovf_reg, ovf_fw, udf_reg, udf_fw;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_dout_reg;
  bit               ovf_m, udf_m;

  sync_fifo_fwft_thr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THR(AF_THR), .AE_THR(AE_THR)) u_dut_reg (
    .clk(t_clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd), .dout(dout_reg),
    .used_cnt(used_reg), .empty(empty_reg), .full(full_reg), .almost_full(af_reg),
    .almost_empty(ae_reg), .overflow(ovf_reg), .underflow(udf_reg), .err_clr(err_clr));

  sync_fifo_fwft_thr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THR(AF_THR), .AE_THR(AE_THR)) u_dut_fwft (
    .clk(t_clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd), .dout(dout_fw),
    .used_cnt(used_fw), .empty(empty_fw), .full(full_fw), .almost_full(af_fw),
    .almost_empty(ae_fw), .overflow(ovf_fw), .underflow(udf_fw), .err_clr(err_clr));

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = sb_q.size();
    check("used_reg",  32'(used_reg),  32'(n));
    check("used_fw",   32'(used_fw),   32'(n));
    check("empty_reg", 32'(empty_reg), 32'(n == 0));
    check("empty_fw",  32'(empty_fw),  32'(n == 0));
    check("full_reg",  32'(full_reg),  32'(n == DEPTH));
    check("full_fw",   32'(full_fw),   32'(n == DEPTH));
    check("af_reg",    32'(af_reg),    32'(n >= AF_THR));
    check("af_fw",     32'(af_fw),     32'(n >= AF_THR));
    check("ae_reg",    32'(ae_reg),    32'(n <= AE_THR));
    check("ae_fw",     32'(ae_fw),     32'(n <= AE_THR));
    check("ovf_reg",   32'(ovf_reg),   32'(ovf_m));
    check("ovf_fw",    32'(ovf_fw),    32'(ovf_m));
    check("udf_reg",   32'(udf_reg),   32'(udf_m));
    check("udf_fw",    32'(udf_fw),    32'(udf_m));
    check("dout_reg",  dout_reg,       exp_dout_reg);
    if (n != 0) check("dout_fw", dout_fw, sb_q[0]);
    check("ef_excl_reg", 32'(empty_reg & full_reg), 32'd0);
    check("ef_excl_fw",  32'(empty_fw & full_fw),   32'd0);
  endtask

  // One clock of stimulus; reference model updated from its own pre-edge state.
  task automatic step(input bit w, input logic [31:0] d, input bit r, input bit f, input bit ec);
    int  n;
    bit  wacc, racc, fm, em;
    wr = w; din = d; rd = r; flush = f; err_clr = ec;
    n    = sb_q.size();
    fm   = (n == DEPTH);
    em   = (n == 0);
    wacc = w && !fm && !f;
    racc = r && !em && !f;
    ovf_m = (w && fm && !f) || (ovf_m && !ec);
    udf_m = (r && em && !f) || (udf_m && !ec);
    if (f) begin
      sb_q.delete();
    end else begin
      if (racc) exp_dout_reg = sb_q.pop_front();
      if (wacc) sb_q.push_back(d);
    end
    @(posedge t_clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_dout_reg = 32'h0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endtask

  initial begin
    int wp, rp;
    rst = 1'b1; flush = 1'b0; wr = 1'b0; din = 32'h0; rd = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge t_clk);
    #1;
    rst = 1'b0;
    check_all();

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
      if (i == 11) check("af_before_thr", 32'(af_reg), 32'd0);
      if (i == 12) check("af_at_thr", 32'(af_reg), 32'd1);
    end
    check("fill_full", 32'(full_reg), 32'd1);
    check("fill_used", 32'(used_reg), 32'd15);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("drain_seq", dout_reg, 32'h100 + 32'(i));
    end
    check("drain_empty", 32'(empty_reg), 32'd1);

    // Fall-through latency
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    check("fwft_nonempty", 32'(empty_fw), 32'd0);
    check("fwft_word", dout_fw, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fwft_empty_after", 32'(empty_fw), 32'd1);
    check("fwft_used_after", 32'(used_fw), 32'd0);

    // Wrap-around at constant occupancy 7
    for (int i = 0; i < 7; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
      check("wrap_used", 32'(used_reg), 32'd7);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Boundary errors
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000BAD, 1'b1, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_reg), 32'd1);
    check("ovf_used", 32'(used_reg), 32'd14);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drop_not_stored", dout_reg, 32'h40E);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    check("udf_set", 32'(udf_reg), 32'd1);
    check("udf_used", 32'(used_reg), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(ovf_fw), 32'd0);
    check("clr_udf", 32'(udf_fw), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with pending wr/rd; underflow set beforehand must survive
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h666, 1'b1, 1'b1, 1'b0);
    check("flush_used", 32'(used_reg), 32'd0);
    check("flush_ae", 32'(ae_reg), 32'd1);
    check("flush_udf_kept", 32'(udf_reg), 32'd1);
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    check("flush_new_fw", dout_fw, 32'h77);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("flush_new_reg", dout_reg, 32'h77);

    // Async reset between edges with traffic pending
    for (int i = 0; i < 5; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    wr = 1'b1; rd = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_used", 32'(used_reg), 32'd0);
    check("arst_empty", 32'(empty_fw), 32'd1);
    check("arst_dout", dout_reg, 32'h0);
    check("arst_udf", 32'(udf_reg), 32'd0);
    @(posedge t_clk);
    #1;
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    check_all();

    // Random traffic with drifting write/read bias to reach both boundaries
    wp = 50; rp = 50;
    for (int c = 0; c < 20000; c++) begin
      if (c % 256 == 0) begin
        wp = int'($urandom_range(10, 90));
        rp = int'($urandom_range(10, 90));
      end
      step(int'($urandom_range(0, 99)) < wp, $urandom, int'($urandom_range(0, 99)) < rp,
           $urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
